// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: per-channel polarity, mask and W1C pending bits.
// PEND sets one clock after a detected edge; irq follows active by one clock (pulse or level).
module irq_ctrl #(
    parameter int NCH        = 4,
    parameter int PULSE_LEN  = 11,
    parameter bit LEVEL_MODE = 1'b0
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic [NCH-1:0] src,
    input  logic           cs,
    input  logic           rw,
    input  logic [1:0]     addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic           irq,
    output logic [3:0]     vec
);
    localparam logic [7:0] CH_BITS = 8'((9'd1 << NCH) - 9'd1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Registers are kept 8 bits wide; bits above NCH are forced to zero.
    logic [7:0]     mask;
    logic [7:0]     pend;
    logic [7:0]     pol;
    logic [NCH-1:0] prev;
    logic           armed;

    logic [7:0]     edges;
    logic [7:0]     w1c;
    logic [7:0]     active;
    logic           any_active;
    logic [2:0]     low_idx;
    logic           wr_en;
    logic           irq_q;
    logic [7:0]     rd_data;

    assign wr_en = cs & ~rw;
    assign edges = armed ? (8'((prev ^ src) & ~(src ^ pol[NCH-1:0])) & CH_BITS) : 8'h00;
    assign w1c   = (wr_en && addr == 2'd1) ? din : 8'h00;

    assign active     = pend & mask;
    assign any_active = |active;

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign vec = {any_active, any_active ? low_idx : 3'd0};
    assign irq = irq_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mask  <= 8'h00;
            pend  <= 8'h00;
            pol   <= 8'h00;
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= src;
            armed <= 1'b1;
            // A new edge wins over a simultaneous clear of the same bit.
            pend  <= (pend & ~w1c) | edges;
            if (wr_en && addr == 2'd0) begin
                mask <= din & CH_BITS;
            end
            if (wr_en && addr == 2'd2) begin
                pol <= din & CH_BITS;
            end
        end
    end

    always_comb begin
        case (addr)
            2'd0:    rd_data = mask;
            2'd1:    rd_data = pend;
            2'd2:    rd_data = pol;
            default: rd_data = {irq_q, 3'b000, vec};
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dout <= 8'hff;
        end else begin
            dout <= (cs && rw) ? rd_data : 8'hff;
        end
    end

    generate
        if (LEVEL_MODE) begin : g_level
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    irq_q <= 1'b0;
                end else begin
                    irq_q <= any_active;
                end
            end
        end else begin : g_pulse
            logic [1:0] state;
            logic [7:0] cnt;

            assign irq_q = (state == ST_PULSE);

            // A pulse always runs to completion; WAIT holds off re-triggering until active drops.
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    state <= ST_IDLE;
                    cnt   <= 8'd0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (any_active) begin
                                state <= ST_PULSE;
                                cnt   <= 8'(PULSE_LEN - 1);
                            end
                        end
                        ST_PULSE: begin
                            if (cnt == 8'd0) begin
                                state <= ST_WAIT;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                        ST_WAIT: begin
                            if (!any_active) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: pulsed instance under full test, level instance shadowing it.
module tb_irq_ctrl;
    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic [3:0] vec;
    logic [7:0] dout_l;
    logic       irq_l;
    logic [3:0] vec_l;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    irq_ctrl #(.NCH(4), .PULSE_LEN(11), .LEVEL_MODE(1'b0)) dut (
        .clk_sys(clk_sys), .reset(reset), .src(src), .cs(cs), .rw(rw),
        .addr(addr), .din(din), .dout(dout), .irq(irq), .vec(vec)
    );

    irq_ctrl #(.NCH(4), .PULSE_LEN(11), .LEVEL_MODE(1'b1)) dut_l (
        .clk_sys(clk_sys), .reset(reset), .src(src), .cs(cs), .rw(rw),
        .addr(addr), .din(din), .dout(dout_l), .irq(irq_l), .vec(vec_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; din = d;
        tick();
        cs = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cs = 1'b1; rw = 1'b1; addr = a;
        tick();
        cs = 1'b0; rw = 1'b0;
        chk(tag, dout, exp);
    endtask

    initial begin
        int hi;
        reset = 1'b1; src = 4'h0; cs = 1'b0; rw = 1'b0; addr = 2'd0; din = 8'h00;
        @(negedge clk_sys);
        tick();
        chk("rst_irq", irq, 1'b0);
        chk("rst_dout", dout, 8'hff);
        chk("rst_vec", vec, 4'h0);
        reset = 1'b0;
        tick();
        rd("rst_mask", 2'd0, 8'h00);
        rd("rst_pend", 2'd1, 8'h00);
        rd("rst_pol", 2'd2, 8'h00);
        rd("rst_stat", 2'd3, 8'h00);
        tick();
        chk("dout_idle", dout, 8'hff);

        // Falling edge on src[0] with MASK=1 gives an 11-clock pulse two clocks later.
        wr(2'd0, 8'h01);
        src = 4'b0001; tick(); tick();
        chk("rise_ignored", vec, 4'h0);
        src = 4'b0000; tick();
        chk("p1_irq_lat1", irq, 1'b0);
        chk("p1_vec", vec, 4'b1000);
        chk("p1_lvl_lat1", irq_l, 1'b0);
        tick();
        chk("p1_irq_start", irq, 1'b1);
        chk("p1_lvl_start", irq_l, 1'b1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (irq) hi++;
            tick();
        end
        chk("p1_width", 8'(hi), 8'd11);
        rd("p1_stat", 2'd3, 8'h08);
        wr(2'd1, 8'h01);
        rd("p1_cleared", 2'd1, 8'h00);

        // Masked edge on src[2] pends silently, then unmasking fires.
        wr(2'd0, 8'h00);
        src = 4'b0100; tick(); tick();
        src = 4'b0000; tick(); tick();
        rd("p2_pend", 2'd1, 8'h04);
        rd("p2_pend_again", 2'd1, 8'h04);
        chk("p2_irq_masked", irq, 1'b0);
        chk("p2_lvl_masked", irq_l, 1'b0);
        wr(2'd0, 8'h04);
        chk("p2_vec", vec, 4'b1010);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (irq) hi++;
            tick();
        end
        chk("p2_width", 8'(hi), 8'd11);
        wr(2'd1, 8'h04);

        // Edge on src[1] coincides with W1C of bits 1 and 3.
        src = 4'b1010; tick();
        src = 4'b0000; tick(); tick();
        rd("p3_pre", 2'd1, 8'h0a);
        src = 4'b0010; tick(); tick();
        src = 4'b0000;
        cs = 1'b1; rw = 1'b0; addr = 2'd1; din = 8'h0a;
        tick();
        cs = 1'b0;
        rd("p3_set_wins", 2'd1, 8'h02);
        wr(2'd1, 8'h02);
        rd("p3_clear", 2'd1, 8'h00);

        // Priority encoding and FSM re-arm after all pending bits clear.
        wr(2'd0, 8'h03);
        src = 4'b0011; tick();
        src = 4'b0000; tick();
        chk("p4_vec_both", vec, 4'b1000);
        repeat (15) tick();
        chk("p4_wait_irq", irq, 1'b0);
        wr(2'd1, 8'h01);
        chk("p4_vec_ch1", vec, 4'b1001);
        wr(2'd1, 8'h02);
        chk("p4_vec_none", vec, 4'h0);
        tick();
        chk("p4_idle_irq", irq, 1'b0);
        src = 4'b0001; tick();
        src = 4'b0000; tick(); tick();
        chk("p4_repulse", irq, 1'b1);
        repeat (12) tick();
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h00);

        // Rising polarity with src[3] high across reset release.
        src = 4'b1000;
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        wr(2'd2, 8'h08);
        rd("p5_pol", 2'd2, 8'h08);
        tick(); tick();
        rd("p5_static", 2'd1, 8'h00);
        src = 4'b0000; tick(); tick();
        rd("p5_fall_ignored", 2'd1, 8'h00);
        src = 4'b1000; tick(); tick();
        rd("p5_rise", 2'd1, 8'h08);

        // Asynchronous reset on clock 5 of a pulse.
        wr(2'd0, 8'h08);
        repeat (5) tick();
        chk("p6_irq_mid", irq, 1'b1);
        chk("p6_lvl_mid", irq_l, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("p6_irq_async", irq, 1'b0);
        chk("p6_lvl_async", irq_l, 1'b0);
        chk("p6_dout_async", dout, 8'hff);
        chk("p6_vec_async", vec, 4'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        tick();
        rd("p6_mask", 2'd0, 8'h00);
        rd("p6_pend", 2'd1, 8'h00);
        rd("p6_pol", 2'd2, 8'h00);
        rd("p6_stat", 2'd3, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of interrupt source channels (legal 1..8).
REQ-002 SHALL have parameter PULSE_LEN, default 11, irq pulse width in clocks (legal 1..255).
REQ-003 SHALL have parameter LEVEL_MODE, default 0, meaning 0 = pulsed irq and 1 = level irq.
REQ-004 SHALL have port clk_sys  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port src  input  NCH  raw interrupt sources, already synchronous to clk_sys.
REQ-007 SHALL have port cs  input  1  register access select.
REQ-008 SHALL have port rw  input  1  1 = read, 0 = write.
REQ-009 SHALL have port addr  input  2  register index.
REQ-010 SHALL have port din  input  8  write data.
REQ-011 SHALL have port dout  output  8  registered read data.
REQ-012 SHALL have port irq  output  1  interrupt request to CPU.
REQ-013 SHALL have port vec  output  4  bit3 = valid, bits[2:0] = lowest active channel index.

Function
REQ-014 SHALL use this register map: addr0 MASK (R/W), addr1 PEND (R; write-1-to-clear), addr2 POL (R/W; bit n = 1 rising edge, 0 falling edge), addr3 STAT (R only; {irq, 3'b0, vec}).
REQ-015 SHALL implement NCH bits for MASK, PEND and POL; bits NCH..7 SHALL read 0 and SHALL ignore writes.
REQ-016 SHALL register src into prev every cycle and SHALL detect an edge on channel n when prev[n] != src[n] and src[n] == POL[n].
REQ-017 SHALL suppress edge detection on the first clock after reset deassertion (armed flag 0 -> 1) so a source static at reset release does not set PEND.
REQ-018 SHALL set PEND[n] one clock after its detected edge, regardless of MASK[n].
REQ-019 SHALL let set win when an edge and a W1C hit the same PEND bit in the same cycle; other bits SHALL clear normally.
REQ-020 SHALL define active = PEND & MASK and SHALL drive vec combinationally from active: valid = |active, index = lowest set bit, index = 0 when invalid.
REQ-021 SHALL, when LEVEL_MODE = 1, drive irq as a register equal to |active of the previous cycle.
REQ-022 SHALL, when LEVEL_MODE = 0, run FSM IDLE/PULSE/WAIT with irq = 1 only in PULSE.
REQ-023 SHALL transition IDLE -> PULSE when |active = 1, loading the 8-bit counter with PULSE_LEN-1.
REQ-024 SHALL, in PULSE, decrement the counter each clock and go to WAIT after exactly PULSE_LEN irq-high clocks.
REQ-025 SHALL stay in WAIT while |active = 1 and return to IDLE on the first clock with |active = 0; no new pulse SHALL fire until IDLE is reached.
REQ-026 SHALL not abort a PULSE when active clears or MASK changes mid-pulse.
REQ-027 SHALL update write registers on the clock where cs = 1 and rw = 0; writes to STAT SHALL be ignored.
REQ-028 SHALL return register contents on dout one clock after cs = 1 and rw = 1, and SHALL return 8'hff on every other cycle.
REQ-029 SHALL not alter PEND as a side effect of any read.

Reset
REQ-030 SHALL on reset clear MASK, PEND, prev and armed to 0, set POL to 0 (falling edge), clear the counter, force FSM to IDLE, and drive irq = 0 and dout = 8'hff.
REQ-031 SHALL apply reset mid-pulse immediately (asynchronously), dropping irq with no pending state kept.

Verification
REQ-032 SHALL be covered by a test where, with defaults, MASK = 1, src[0] goes 1 -> 0 -> irq high for exactly 11 clocks starting 2 clocks after the edge, then STAT reads 8'h08.
REQ-033 SHALL be covered by a test where, with MASK = 0, an edge on src[2] -> PEND reads 8'h04 and irq stays 0; a subsequent write MASK = 4 -> 11-clock pulse and vec = 4'b1010.
REQ-034 SHALL be covered by a test where an edge on src[1] occurs in the same cycle as a write of PEND = 8'h02 -> PEND[1] stays 1.
REQ-035 SHALL be covered by a test where PEND = 3 and MASK = 3 -> vec = 4'b1000; after W1C 8'h01, vec = 4'b1001; after W1C 8'h02, FSM returns to IDLE and a new edge produces a new pulse.
REQ-036 SHALL be covered by a test where POL = 1, src[3] is held high through reset release -> no PEND; then 0 -> 1 -> PEND[3] = 1.
REQ-037 SHALL be covered by a test where reset is asserted at clock 5 of a pulse -> irq = 0 immediately, and all registers read reset values.
